// File: rtl/lut_neuron_scheduler.sv
// Shared truth-table RAM time-multiplexed across the LUT neurons of one layer.
// One registered lookup per neuron per input vector; results are gathered into out_data.
module lut_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int FAN_IN    = 6,
  parameter int OUT_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic [$clog2(N_NEURONS)+FAN_IN-1:0] cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  output logic                            cfg_busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_NEURONS*FAN_IN-1:0]     in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]   out_data
);

  localparam int NW    = $clog2(N_NEURONS);
  localparam int AW    = NW + FAN_IN;
  localparam int DEPTH = N_NEURONS * (2 ** FAN_IN);

  typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUT} state_t;

  state_t                        state, state_nxt;
  logic [NW-1:0]                 counter;
  logic [N_NEURONS*FAN_IN-1:0]   in_reg;
  logic [OUT_BITS-1:0]           mem [DEPTH];
  logic [OUT_BITS-1:0]           rd_data;
  logic [AW-1:0]                 rd_addr;
  logic [FAN_IN-1:0]             cur_slice;
  logic                          rd_valid;
  logic [NW-1:0]                 rd_slot;
  logic                          last;
  logic                          accept;
  logic                          cfg_wr;

  assign last    = (counter == NW'(N_NEURONS - 1));
  assign accept  = in_valid && in_ready;
  assign cfg_wr  = cfg_we && !cfg_busy;
  assign rd_addr = {counter, cur_slice};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A config write in IDLE wins over an incoming vector in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_busy  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        cfg_busy = 1'b0;
        in_ready = !cfg_we;
        if (in_valid && !cfg_we) state_nxt = EVAL;
      end
      EVAL: begin
        if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_slice = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      if (counter == NW'(n)) cur_slice = in_reg[n*FAN_IN +: FAN_IN];
    end
  end

  // Table RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (cfg_wr) mem[cfg_addr] <= cfg_wdata;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      in_reg   <= '0;
      rd_valid <= 1'b0;
      rd_slot  <= '0;
      out_data <= '0;
    end else begin
      rd_valid <= (state == EVAL);
      rd_slot  <= counter;
      if (accept) begin
        in_reg  <= in_data;
        counter <= '0;
      end else if (state == EVAL && !last) begin
        counter <= counter + NW'(1);
      end
      // rd_valid is only ever high in the cycle after an EVAL read, i.e. in EVAL or DRAIN.
      for (int n = 0; n < N_NEURONS; n++) begin
        if (rd_valid && rd_slot == NW'(n)) out_data[n*OUT_BITS +: OUT_BITS] <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_scheduler.sv
// Scoreboard bench for lut_neuron_scheduler: a table model predicts each result,
// and a monitor pops and compares on every output handshake.
module tb_lut_neuron_scheduler;

  localparam int N  = 4;
  localparam int F  = 6;
  localparam int O  = 2;
  localparam int NW = 2;
  localparam int DW = N * F;
  localparam int RW = N * O;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [NW+F-1:0] cfg_addr = '0;
  logic [O-1:0]  cfg_wdata = '0;
  logic          cfg_busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_data;

  logic [O-1:0]  tbl [N][2**F];
  logic [RW-1:0] expq [$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  lut_neuron_scheduler #(.N_NEURONS(N), .FAN_IN(F), .OUT_BITS(O)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [RW-1:0] model(input logic [DW-1:0] d);
    logic [RW-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*O +: O] = tbl[n][d[n*F +: F]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got %0h with empty scoreboard", out_data);
      end else begin
        checkOutput("result", 32'(out_data), 32'(expq.pop_front()));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfgWrite(input int n, input int p, input logic [O-1:0] v, input bit taken);
    cfg_addr  = {NW'(n), F'(p)};
    cfg_wdata = v;
    cfg_we    = 1'b1;
    @(negedge clk);
    checkOutput("cfg_busy", 32'(cfg_busy), 32'(!taken));
    @(posedge clk);
    if (taken) tbl[n][p] = v;
    #1 cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, output time t);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    t = $time;
    if (ok) expq.push_back(model(d));
    #1 in_valid = 1'b0;
    checkOutput("accept", 32'(ok), 32'd1);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    checkOutput("result timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] vec1, vec2, v;
    logic [RW-1:0] exp1;
    int   lat;
    time  t, tprev;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset cfg_busy", 32'(cfg_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    // Scenario 1: load tables, known vector, latency
    for (int n = 0; n < N; n++)
      for (int p = 0; p < 2**F; p++) cfgWrite(n, p, O'(n), 1'b1);
    cfgWrite(0, 'h2D, 2'b10, 1'b1);
    vec1 = {6'h01, 6'h3F, 6'h00, 6'h2D};
    applyStimulus(vec1, t);
    waitResult(lat);
    checkOutput("latency", 32'(lat), 32'(N + 1));
    checkOutput("scenario1 data", 32'(out_data), 32'b11100110);

    // Scenario 2: output backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    v = 24'($urandom);
    exp1 = model(v);
    applyStimulus(v, t);
    waitResult(lat);
    vec2 = 24'($urandom);
    in_data  = vec2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("held out_valid", 32'(out_valid), 32'd1);
      checkOutput("held out_data", 32'(out_data), 32'(exp1));
      checkOutput("held in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("in_ready during handshake", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready after release", 32'(in_ready), 32'd1);
    @(posedge clk);
    expq.push_back(model(vec2));
    #1 in_valid = 1'b0;
    waitResult(lat);
    checkOutput("latency after backpressure", 32'(lat), 32'(N + 1));

    // Scenario 3: write during EVAL is dropped
    @(posedge clk);
    #1;
    v = 24'($urandom);
    v[F +: F] = '0;
    applyStimulus(v, t);
    cfgWrite(1, 0, 2'b11, 1'b0);
    waitResult(lat);
    checkOutput("slot1 after busy write", 32'(out_data[O +: O]), 32'b01);
    @(posedge clk);
    #1;
    v = 24'($urandom);
    v[F +: F] = '0;
    applyStimulus(v, t);
    waitResult(lat);
    checkOutput("slot1 re-evaluated", 32'(out_data[O +: O]), 32'b01);

    // Scenario 4: write and vector in the same IDLE cycle
    @(posedge clk);
    #1;
    v = 24'($urandom);
    v[2*F +: F] = 6'h15;
    cfg_addr  = {2'd2, 6'h15};
    cfg_wdata = 2'b00;
    cfg_we    = 1'b1;
    in_data   = v;
    in_valid  = 1'b1;
    @(negedge clk);
    checkOutput("in_ready with cfg_we", 32'(in_ready), 32'd0);
    checkOutput("cfg_busy in idle", 32'(cfg_busy), 32'd0);
    @(posedge clk);
    tbl[2][6'h15] = 2'b00;
    #1 cfg_we = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after write", 32'(in_ready), 32'd1);
    @(posedge clk);
    expq.push_back(model(v));
    #1 in_valid = 1'b0;
    waitResult(lat);
    checkOutput("slot2 new entry", 32'(out_data[2*O +: O]), 32'b00);

    // Scenario 5: reset mid-EVAL and mid-OUT
    @(posedge clk);
    #1;
    applyStimulus(vec1, t);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("out_valid in reset (eval)", 32'(out_valid), 32'd0);
    checkOutput("out_data in reset", 32'(out_data), 32'd0);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(vec1, t);
    waitResult(lat);
    rst_n = 1'b0;
    #1;
    checkOutput("out_valid in reset (out)", 32'(out_valid), 32'd0);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(vec1, t);
    waitResult(lat);
    checkOutput("table retained", 32'(out_data), 32'b11100110);

    // Scenario 6: random table updates, then back-to-back vectors
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++)
      cfgWrite(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2**F - 1)), O'($urandom), 1'b1);
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(24'($urandom), t);
      if (i > 0) checkOutput("accept interval", 32'(t - tprev), 32'd70);
      tprev = t;
    end

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
